flag_sched: RTL and testbench
=============================

FLAG_SCHED -- requirements
Module: flag_sched

Interface
REQ-001 The clock port SHALL be `clk`, input, 1 bit.
REQ-002 The reset port SHALL be `rst`, input, 1 bit; one clock; reset is synchronous and active-high.
REQ-003 `ex_valid` SHALL be an input, 1 bit: the EX-stage instruction is live.
REQ-004 `ex_flush` SHALL be an input, 1 bit: the EX-stage instruction is squashed this cycle.
REQ-005 `ex_opcode` SHALL be an input, 4 bits: the EX-stage opcode.
REQ-006 `stall_in` SHALL be an input, 1 bit: the pipeline is frozen externally this cycle.
REQ-007 `id_branch` SHALL be an input, 1 bit: the ID stage holds a valid B or BR instruction.
REQ-008 `id_ccc` SHALL be an input, 3 bits: the branch condition code.
REQ-009 `flag_Z`, `flag_N`, `flag_V` SHALL be inputs, 1 bit each, carrying the current flag-register outputs.
REQ-010 `en_Z`, `en_N`, `en_V` SHALL be outputs, 1 bit each, driving the flag-register write enables.
REQ-011 `branch_stall` SHALL be an output, 1 bit: hold ID and bubble EX.
REQ-012 `branch_resolve` and `branch_taken` SHALL be outputs, 1 bit each; `branch_taken` is valid only while `branch_resolve` = 1.
REQ-013 `stall_cnt` SHALL be an output, 16 bits: the count of branch-hazard stall cycles.

Function
REQ-014 Flag writers SHALL be ADD(0000)/SUB(0001) → Z,N,V; XOR(0010)/SLL(0100)/SRA(0101)/ROR(0110) → Z only; all other opcodes → none.
REQ-015 The enables SHALL be combinational: en_x = ex_valid & ~ex_flush & ~stall_in & writer(x).
REQ-016 The condition decode SHALL be:
- 000 NE: Z=0
- 001 EQ: Z=1
- 010 GT: Z=0 & N=0
- 011 LT: N=1
- 100 GTE: Z=1 | N=0
- 101 LTE: N=1 | Z=1
- 110 OV: V=1
- 111 always
REQ-017 The block SHALL contain an FSM with two states, RUN and HOLD; the reset state is RUN.
REQ-018 A hazard SHALL be defined as RUN & id_branch & ~stall_in & (en_Z | en_N | en_V).
REQ-019 In RUN with a hazard, the block SHALL assert branch_stall = 1 and branch_resolve = 0, and move to HOLD at the next edge.
REQ-020 In RUN with id_branch & ~stall_in and no hazard, the block SHALL assert branch_resolve = 1 and evaluate branch_taken from flag_* the same cycle, with zero stall.
REQ-021 In HOLD with ~stall_in, the block SHALL assert branch_resolve = 1, evaluate branch_taken from the newly written flag_*, keep branch_stall = 0, and return to RUN.
REQ-022 In HOLD with stall_in = 1, the block SHALL remain in HOLD with branch_resolve = 0 and branch_stall = 0.
REQ-023 A squashed writer (ex_flush = 1) SHALL NOT create a hazard.
REQ-024 While stall_in = 1, branch_resolve SHALL be 0 in both states.
REQ-025 Each cycle with branch_stall = 1 SHALL increment stall_cnt, saturating at 0xFFFF with no wrap.
REQ-026 The branch hazard latency SHALL be exactly one stall cycle when stall_in stays 0.

Reset
REQ-027 rst = 1 at an edge SHALL force state RUN and stall_cnt = 0, overriding all other inputs.
REQ-028 During and after reset, branch_stall and branch_resolve SHALL be 0 until a new id_branch arrives; enables follow REQ-015 combinationally.
REQ-029 A reset asserted in HOLD SHALL abandon the pending resolve without emitting one.

Structure
REQ-030 The opcode constants, the ccc encodings and the RUN/HOLD state encoding SHALL live in the shared ISA package.
REQ-031 The condition evaluator SHALL be a combinational sub-module named `cond_eval` (ccc, Z, N, V → taken).
REQ-032 flag_sched SHALL instantiate no flag storage; the flag register stays external.

Verification
REQ-033 ex ADD valid, id_branch ccc=001 → cycle 0: en_Z = en_N = en_V = 1, branch_stall = 1; cycle 1 with flag_Z = 1: branch_resolve = 1, branch_taken = 1, stall_cnt = 1.
REQ-034 ex LW, id_branch ccc=011, flag_N = 1 → same cycle: branch_resolve = 1, branch_taken = 1, branch_stall = 0, enables all 0.
REQ-035 ex XOR with ex_flush = 1, id_branch ccc=000 → no stall; resolve same cycle; en_Z = 0.
REQ-036 Hazard, then stall_in = 1 for 2 cycles in HOLD → branch_resolve stays 0 for those 2 cycles, asserts on the 3rd; stall_cnt += 1.
REQ-037 Force stall_cnt = 0xFFFF, then a hazard → stall_cnt stays 0xFFFF.
REQ-038 rst asserted while in HOLD → next cycle state is RUN, branch_resolve = 0, stall_cnt = 0.

Source files
------------

// File: rtl/flag_sched_pkg.sv
// Shared ISA constants for the flag scheduler: writer opcodes, branch
// condition codes and the branch-hazard FSM state encoding.
package flag_sched_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    typedef enum logic [2:0] {
        CC_NE  = 3'b000,
        CC_EQ  = 3'b001,
        CC_GT  = 3'b010,
        CC_LT  = 3'b011,
        CC_GTE = 3'b100,
        CC_LTE = 3'b101,
        CC_OV  = 3'b110,
        CC_AL  = 3'b111
    } ccc_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Flags written by an opcode, packed as {Z, N, V}.
    function automatic logic [2:0] flag_writes(input logic [3:0] op);
        logic [2:0] w;
        case (op)
            OP_ADD, OP_SUB:                 w = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: w = 3'b100;
            default:                        w = 3'b000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/flag_sched_cond_eval.sv
// Combinational branch condition evaluator: ccc and current flags -> taken.
module cond_eval
    import flag_sched_pkg::*;
(
    input  logic [2:0] ccc_i,
    input  logic       z_i,
    input  logic       n_i,
    input  logic       v_i,
    output logic       taken_o
);

    // Decode the condition code against the flag values.
    always_comb begin
        taken_o = 1'b0;
        case (ccc_e'(ccc_i))
            CC_NE:   taken_o = ~z_i;
            CC_EQ:   taken_o = z_i;
            CC_GT:   taken_o = ~z_i & ~n_i;
            CC_LT:   taken_o = n_i;
            CC_GTE:  taken_o = z_i | ~n_i;
            CC_LTE:  taken_o = n_i | z_i;
            CC_OV:   taken_o = v_i;
            CC_AL:   taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_sched.sv
// Flag write-enable generation and branch/flag hazard scheduling: a branch
// in ID that depends on flags being written in EX is held for one cycle.
module flag_sched
    import flag_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_flush,
    input  logic [3:0]  ex_opcode,
    input  logic        stall_in,
    input  logic        id_branch,
    input  logic [2:0]  id_ccc,
    input  logic        flag_Z,
    input  logic        flag_N,
    input  logic        flag_V,
    output logic        en_Z,
    output logic        en_N,
    output logic        en_V,
    output logic        branch_stall,
    output logic        branch_resolve,
    output logic        branch_taken,
    output logic [15:0] stall_cnt
);

    state_e      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [2:0]  writes;
    logic        ex_live;
    logic        hazard;
    logic        cond_taken;
    logic        stall_raw, resolve_raw;

    assign writes  = flag_writes(ex_opcode);
    assign ex_live = ex_valid & ~ex_flush & ~stall_in;
    assign en_Z    = ex_live & writes[2];
    assign en_N    = ex_live & writes[1];
    assign en_V    = ex_live & writes[0];

    assign hazard = (state_q == ST_RUN) & id_branch & ~stall_in & (en_Z | en_N | en_V);

    cond_eval u_cond_eval (
        .ccc_i   (id_ccc),
        .z_i     (flag_Z),
        .n_i     (flag_N),
        .v_i     (flag_V),
        .taken_o (cond_taken)
    );

    // Next-state and stall/resolve decode for the hazard FSM.
    always_comb begin
        state_d     = state_q;
        stall_raw   = 1'b0;
        resolve_raw = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hazard) begin
                    stall_raw = 1'b1;
                    state_d   = ST_HOLD;
                end else if (id_branch && !stall_in) begin
                    resolve_raw = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (!stall_in) begin
                    resolve_raw = 1'b1;
                    state_d     = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // A reset cycle suppresses stall/resolve so a pending HOLD is abandoned.
    assign branch_stall   = stall_raw & ~rst;
    assign branch_resolve = resolve_raw & ~rst;
    assign branch_taken   = branch_resolve & cond_taken;

    // Saturating count of branch-hazard stall cycles.
    always_comb begin
        if (branch_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_flag_sched.sv
// Directed self-checking bench for flag_sched: single-cycle vector table
// followed by hand-written hazard, stall, saturation and reset sequences.
module tb_flag_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_flush, stall_in, id_branch;
    logic [3:0]  ex_opcode;
    logic [2:0]  id_ccc;
    logic        flag_Z, flag_N, flag_V;
    logic        en_Z, en_N, en_V;
    logic        branch_stall, branch_resolve, branch_taken;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flag_sched dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_flush       (ex_flush),
        .ex_opcode      (ex_opcode),
        .stall_in       (stall_in),
        .id_branch      (id_branch),
        .id_ccc         (id_ccc),
        .flag_Z         (flag_Z),
        .flag_N         (flag_N),
        .flag_V         (flag_V),
        .en_Z           (en_Z),
        .en_N           (en_N),
        .en_V           (en_V),
        .branch_stall   (branch_stall),
        .branch_resolve (branch_resolve),
        .branch_taken   (branch_taken),
        .stall_cnt      (stall_cnt)
    );

    typedef struct {
        logic       ev, ef;
        logic [3:0] op;
        logic       si, ib;
        logic [2:0] cc;
        logic       z, n, v;
        logic [2:0] en;
        logic       st, rs, tk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ev, logic ef, logic [3:0] op, logic si, logic ib,
                                logic [2:0] cc, logic z, logic n, logic v,
                                logic [2:0] en, logic st, logic rs, logic tk);
        vec_t t;
        t.ev = ev; t.ef = ef; t.op = op; t.si = si; t.ib = ib; t.cc = cc;
        t.z = z; t.n = n; t.v = v; t.en = en; t.st = st; t.rs = rs; t.tk = tk;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic ef, input logic [3:0] op, input logic si,
                         input logic ib, input logic [2:0] cc, input logic z, input logic n,
                         input logic v);
        ex_valid = ev; ex_flush = ef; ex_opcode = op; stall_in = si;
        id_branch = ib; id_ccc = cc; flag_Z = z; flag_N = n; flag_V = v;
    endtask

    logic [15:0] exp_cnt;

    initial begin
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // Single-cycle vectors, FSM stays in RUN throughout.
        // ev ef op stall ib ccc z n v | en{Z,N,V} stall resolve taken
        vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 3'b000, 0, 0, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0001, 1, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0001, 0, 0, 3'b000, 0, 0, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0010, 0, 0, 3'b000, 0, 0, 0, 3'b100, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0100, 0, 0, 3'b000, 0, 0, 0, 3'b100, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0101, 0, 0, 3'b000, 0, 0, 0, 3'b100, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0110, 0, 0, 3'b000, 0, 0, 0, 3'b100, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0011, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0111, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'b1111, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b000, 0, 0, 0, 3'b000, 0, 1, 1));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b000, 1, 0, 0, 3'b000, 0, 1, 0));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b001, 1, 0, 0, 3'b000, 0, 1, 1));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b001, 0, 1, 1, 3'b000, 0, 1, 0));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b010, 0, 0, 0, 3'b000, 0, 1, 1));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b010, 0, 1, 0, 3'b000, 0, 1, 0));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b011, 0, 1, 0, 3'b000, 0, 1, 1));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b011, 1, 0, 1, 3'b000, 0, 1, 0));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b100, 0, 1, 0, 3'b000, 0, 1, 0));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b100, 1, 1, 0, 3'b000, 0, 1, 1));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b101, 0, 0, 1, 3'b000, 0, 1, 0));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b101, 1, 0, 0, 3'b000, 0, 1, 1));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b110, 0, 0, 1, 3'b000, 0, 1, 1));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b110, 1, 1, 0, 3'b000, 0, 1, 0));
        vecs.push_back(mk(1, 0, 4'b1000, 0, 1, 3'b111, 0, 0, 0, 3'b000, 0, 1, 1));
        vecs.push_back(mk(1, 1, 4'b0010, 0, 1, 3'b000, 0, 0, 0, 3'b000, 0, 1, 1));
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 3'b111, 0, 0, 0, 3'b000, 0, 0, 0));

        // Reset behaviour.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", branch_stall, 1'b0);
        chk("rst_resolve", branch_resolve, 1'b0);
        chk("rst_cnt", stall_cnt, 16'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].ev, vecs[i].ef, vecs[i].op, vecs[i].si, vecs[i].ib,
                  vecs[i].cc, vecs[i].z, vecs[i].n, vecs[i].v);
            #1;
            chk($sformatf("vec%0d_en", i), {en_Z, en_N, en_V}, vecs[i].en);
            chk($sformatf("vec%0d_stall", i), branch_stall, vecs[i].st);
            chk($sformatf("vec%0d_resolve", i), branch_resolve, vecs[i].rs);
            if (vecs[i].rs) chk($sformatf("vec%0d_taken", i), branch_taken, vecs[i].tk);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        #1;
        chk("table_cnt", stall_cnt, 16'd0);
        exp_cnt = 16'd0;

        // ADD hazard on an EQ branch: one stall, resolve on newly written Z.
        @(negedge clk);
        drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
        #1;
        chk("haz_en", {en_Z, en_N, en_V}, 3'b111);
        chk("haz_stall", branch_stall, 1'b1);
        chk("haz_resolve", branch_resolve, 1'b0);
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
        #1;
        chk("haz_c1_resolve", branch_resolve, 1'b1);
        chk("haz_c1_taken", branch_taken, 1'b1);
        chk("haz_c1_stall", branch_stall, 1'b0);
        chk("haz_c1_cnt", stall_cnt, exp_cnt);

        // Hazard followed by two externally stalled cycles in HOLD.
        @(negedge clk);
        drive(1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        #1;
        chk("hs_stall", branch_stall, 1'b1);
        exp_cnt = exp_cnt + 16'd1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0);
            #1;
            chk($sformatf("hs_hold%0d_resolve", k), branch_resolve, 1'b0);
            chk($sformatf("hs_hold%0d_stall", k), branch_stall, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0);
        #1;
        chk("hs_resolve", branch_resolve, 1'b1);
        chk("hs_taken", branch_taken, 1'b0);
        chk("hs_cnt", stall_cnt, exp_cnt);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        #1;
        chk("hs_idle_resolve", branch_resolve, 1'b0);

        // Saturation: preload the counter to its maximum, then stall once more.
        @(negedge clk);
        force dut.stall_cnt_q = 16'hFFFF;
        #1;
        release dut.stall_cnt_q;
        #1;
        chk("sat_preload", stall_cnt, 16'hFFFF);
        @(negedge clk);
        drive(1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0);
        #1;
        chk("sat_stall", branch_stall, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1);
        #1;
        chk("sat_cnt", stall_cnt, 16'hFFFF);
        chk("sat_resolve", branch_resolve, 1'b1);
        chk("sat_taken", branch_taken, 1'b1);

        // Reset while in HOLD abandons the resolve and clears the counter.
        @(negedge clk);
        drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rh_stall", branch_stall, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rh_during_resolve", branch_resolve, 1'b0);
        chk("rh_during_stall", branch_stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rh_after_resolve", branch_resolve, 1'b0);
        chk("rh_after_stall", branch_stall, 1'b0);
        chk("rh_after_cnt", stall_cnt, 16'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 4'b1001, 1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 1'b0);
        #1;
        chk("rh_run_resolve", branch_resolve, 1'b1);
        chk("rh_run_taken", branch_taken, 1'b1);
        chk("rh_run_en", {en_Z, en_N, en_V}, 3'b000);

        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
